// File: rtl/motor_pwm_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : motor_pwm_gen
// Purpose  : Dual-channel H-bridge PWM generator fed by the SPI command
//            receiver. Command bytes are captured on the synchronised rising
//            edge of load, held in shadow registers and applied only at PWM
//            period boundaries, so the outputs never glitch mid-period.
//            A direction reversal blanks the channel for one period, and a
//            command watchdog forces both channels off when frames stop.
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_gen #(
  parameter int PRESCALE     = 4,   // clk cycles per PWM count step (>= 1)
  parameter int WDOG_PERIODS = 50   // PWM periods without a frame before trip
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] motor1,
  input  logic [7:0] motor2,
  output logic       pwm1,
  output logic       dir1,
  output logic       pwm2,
  output logic       dir2,
  output logic       wdog_trip
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WD_W = $clog2(WDOG_PERIODS + 1);

  localparam logic [PS_W-1:0] c_ps_last  = PS_W'(PRESCALE - 1);
  localparam logic [6:0]      c_cnt_last = 7'd126;
  localparam logic [WD_W-1:0] c_wd_limit = WD_W'(WDOG_PERIODS);
  localparam logic [WD_W-1:0] c_wd_pre   = WD_W'(WDOG_PERIODS - 1);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic            r_load_s1;
  logic            r_load_s2;
  logic            r_load_s3;
  logic            w_capture;

  logic [PS_W-1:0] r_presc;
  logic            w_tick;
  logic [6:0]      r_count;
  logic            w_boundary;

  logic            r_pending;
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wdog_trip;
  logic            w_wd_expire;

  logic [1:0][7:0] w_cmd;
  logic [1:0]      w_pwm;
  logic [1:0]      w_dir;

  // --------------------------------------------------------------------------
  // load synchroniser and rising-edge detect.
  // The flops idle high so that releasing reset with load high is not seen
  // as a frame. Capture takes effect on the third clk edge after the rise.
  // --------------------------------------------------------------------------
  // Two-flop synchroniser plus one history flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_s1 <= 1'b1;
      r_load_s2 <= 1'b1;
      r_load_s3 <= 1'b1;
    end else begin
      r_load_s1 <= load;
      r_load_s2 <= r_load_s1;
      r_load_s3 <= r_load_s2;
    end
  end

  assign w_capture = r_load_s2 & ~r_load_s3;

  // --------------------------------------------------------------------------
  // Timebase: prescaler feeding a 127-step PWM counter
  // --------------------------------------------------------------------------
  assign w_tick     = (r_presc == c_ps_last);
  assign w_boundary = w_tick && (r_count == c_cnt_last);

  // Prescaler counts 0..PRESCALE-1 and wraps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  // PWM counter advances once per tick, 0..126 then back to 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 7'd0;
    end else if (w_tick) begin
      if (r_count == c_cnt_last) begin
        r_count <= 7'd0;
      end else begin
        r_count <= r_count + 7'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame bookkeeping and watchdog
  // --------------------------------------------------------------------------
  // A capture on a boundary cycle wins, so freshly captured bytes are never
  // dropped when the boundary consumes the previous shadow contents.
  // Pending flag: set by a capture, consumed by the next boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else if (w_capture) begin
      r_pending <= 1'b1;
    end else if (w_boundary) begin
      r_pending <= 1'b0;
    end
  end

  // The trip fires on the boundary that brings the count to WDOG_PERIODS.
  assign w_wd_expire = w_boundary && !w_capture && (r_wd_cnt == c_wd_pre);

  // Watchdog period counter: cleared by capture, saturating at the limit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt <= '0;
    end else if (w_capture) begin
      r_wd_cnt <= '0;
    end else if (w_boundary && (r_wd_cnt != c_wd_limit)) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Trip flag: raised on expiry, cleared only by a new frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog_trip <= 1'b0;
    end else if (w_capture) begin
      r_wdog_trip <= 1'b0;
    end else if (w_wd_expire) begin
      r_wdog_trip <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel command path
  // --------------------------------------------------------------------------
  assign w_cmd[0] = motor1;
  assign w_cmd[1] = motor2;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic [7:0] r_shadow;
    logic [6:0] r_mag;
    logic       r_dir;
    logic       r_blank;
    logic       r_pwm;
    logic [7:0] w_next;

    // Command seen at the boundary: the shadow when a frame is pending,
    // otherwise the currently running command (so direction is unchanged).
    assign w_next = r_pending ? r_shadow : {r_dir, r_mag};

    // Shadow register loads the command byte on capture
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_shadow <= 8'd0;
      end else if (w_capture) begin
        r_shadow <= w_cmd[g];
      end
    end

    // Active command, direction and blanking update only at the boundary;
    // a watchdog expiry zeroes the magnitude but keeps the direction.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_mag   <= 7'd0;
        r_dir   <= 1'b0;
        r_blank <= 1'b0;
      end else if (w_boundary) begin
        r_mag   <= w_wd_expire ? 7'd0 : w_next[6:0];
        r_dir   <= w_next[7];
        r_blank <= w_next[7] ^ r_dir;
      end
    end

    // Registered PWM compare, suppressed while blanked or tripped
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pwm <= 1'b0;
      end else begin
        r_pwm <= !r_blank && !r_wdog_trip && (r_count < r_mag);
      end
    end

    assign w_pwm[g] = r_pwm;
    assign w_dir[g] = r_dir;
  end

  // --------------------------------------------------------------------------
  // Outputs (all driven straight from flops)
  // --------------------------------------------------------------------------
  assign pwm1      = w_pwm[0];
  assign dir1      = w_dir[0];
  assign pwm2      = w_pwm[1];
  assign dir2      = w_dir[1];
  assign wdog_trip = r_wdog_trip;

endmodule
`default_nettype wire

// File: tb/tb_motor_pwm_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_motor_pwm_gen
// Purpose  : Directed self-checking bench for motor_pwm_gen. Expected
//            per-period PWM high times and direction levels are queued when
//            a frame is sent and compared when the period is measured.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_pwm_gen;

  localparam int PER = 508;   // 127 steps * PRESCALE(4)

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] motor1;
  logic [7:0] motor2;
  logic       pwm1;
  logic       dir1;
  logic       pwm2;
  logic       dir2;
  logic       wdog_trip;

  int passed = 0;
  int fails  = 0;
  int total  = 0;
  int cyc;

  typedef struct {
    int   p;
    int   h1;
    int   h2;
    logic d1;
    logic d2;
  } exp_t;

  exp_t sb[$];

  motor_pwm_gen #(
    .PRESCALE     (4),
    .WDOG_PERIODS (50)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .motor1    (motor1),
    .motor2    (motor2),
    .pwm1      (pwm1),
    .dir1      (dir1),
    .pwm2      (pwm2),
    .dir2      (dir2),
    .wdog_trip (wdog_trip)
  );

  always #5 clk = ~clk;

  // Count rising clk edges since reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // Hard stop in case something stalls
  initial begin
    #1500000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int p, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s period=%0d observed=%0d expected=%0d", tag, p, obs, exp);
    end
  endtask

  // Advance (on falling edges) until the edge counter reaches n
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      total++;
      fails++;
      $error("FAIL sched observed_cycle=%0d expected_cycle=%0d", cyc, n);
    end
  endtask

  // Sample one PWM period: pwm reflects the boundary at edge PER*p from
  // edge PER*p+1 through edge PER*(p+1)
  task automatic measure(input int p, output int h1, output int h2, output logic d1, output logic d2);
    h1 = 0;
    h2 = 0;
    wait_cyc(PER * p + 1);
    d1 = dir1;
    d2 = dir2;
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      if (pwm1 === 1'b1) h1++;
      if (pwm2 === 1'b1) h2++;
    end
  endtask

  // SPI frame: bytes wiggle while load is low, settle, then load rises
  // just after edge 'rise'
  task automatic send_frame(input logic [7:0] m1, input logic [7:0] m2, input int rise);
    wait_cyc(rise - 8);
    load = 1'b0;
    @(negedge clk);
    motor1 = ~m1;
    motor2 = ~m2;
    @(negedge clk);
    motor1 = 8'h55;
    motor2 = 8'hAA;
    wait_cyc(rise - 2);
    motor1 = m1;
    motor2 = m2;
    wait_cyc(rise);
    load = 1'b1;
  endtask

  task automatic expect_period(input int p, input int h1, input int h2, input logic d1, input logic d2);
    exp_t e;
    e.p  = p;
    e.h1 = h1;
    e.h2 = h2;
    e.d1 = d1;
    e.d2 = d2;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   h1;
    int   h2;
    logic d1;
    logic d2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      measure(e.p, h1, h2, d1, d2);
      check("pwm1_high", e.p, h1, e.h1);
      check("pwm2_high", e.p, h2, e.h2);
      check("dir1", e.p, {31'd0, d1}, {31'd0, e.d1});
      check("dir2", e.p, {31'd0, d2}, {31'd0, e.d2});
    end
  endtask

  initial begin
    int r;
    reset_n = 1'b0;
    load    = 1'b1;
    motor1  = 8'h00;
    motor2  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm1", -1, pwm1, 0);
    check("rst_pwm2", -1, pwm2, 0);
    check("rst_dir1", -1, dir1, 0);
    check("rst_dir2", -1, dir2, 0);
    check("rst_wdog", -1, wdog_trip, 0);
    reset_n = 1'b1;

    // No frames: outputs idle, watchdog trips on the 50th boundary
    expect_period(0, 0, 0, 1'b0, 1'b0);
    expect_period(1, 0, 0, 1'b0, 1'b0);
    drain();
    wait_cyc(50 * PER - 1);
    check("wdog_before", 50, wdog_trip, 0);
    wait_cyc(50 * PER);
    check("wdog_trip", 50, wdog_trip, 1);

    // motor1=0x40 / motor2=0x7F; trip clears three cycles after load rise
    r = 51 * PER + 110;
    send_frame(8'h40, 8'h7F, r);
    wait_cyc(r + 2);
    check("trip_hold", 51, wdog_trip, 1);
    wait_cyc(r + 3);
    check("trip_clear", 51, wdog_trip, 0);
    expect_period(52, 256, 508, 1'b0, 1'b0);
    drain();

    // Reduce magnitude, then reverse channel 1
    send_frame(8'h20, 8'h7F, 53 * PER + 110);
    expect_period(54, 128, 508, 1'b0, 1'b0);
    drain();
    send_frame(8'hA0, 8'h7F, 55 * PER + 110);
    expect_period(56, 0, 508, 1'b1, 1'b0);
    expect_period(57, 128, 508, 1'b1, 1'b0);
    drain();

    // Pending 0x88, then 0xB0 captured exactly on the next boundary
    send_frame(8'h88, 8'h7F, 58 * PER + 110);
    send_frame(8'hB0, 8'h7F, 59 * PER - 3);
    expect_period(59, 32, 508, 1'b1, 1'b0);
    expect_period(60, 192, 508, 1'b1, 1'b0);
    drain();

    // Last frame motor2=0x50, then silence until the watchdog trips
    send_frame(8'hB0, 8'h50, 61 * PER + 110);
    expect_period(62, 192, 320, 1'b1, 1'b0);
    expect_period(109, 192, 320, 1'b1, 1'b0);
    drain();
    wait_cyc(111 * PER - 1);
    check("wdog2_before", 111, wdog_trip, 0);
    wait_cyc(111 * PER);
    check("wdog2_trip", 111, wdog_trip, 1);
    expect_period(111, 0, 0, 1'b1, 1'b0);
    drain();

    // Recovery frame motor2=0x10
    r = 112 * PER + 110;
    send_frame(8'hB0, 8'h10, r);
    wait_cyc(r + 2);
    check("trip2_hold", 112, wdog_trip, 1);
    wait_cyc(r + 3);
    check("trip2_clear", 112, wdog_trip, 0);
    expect_period(113, 192, 64, 1'b1, 1'b0);
    drain();

    // Asynchronous reset while pwm is high
    wait_cyc(114 * PER + 50);
    check("pre_rst_pwm1", 114, pwm1, 1);
    check("pre_rst_dir1", 114, dir1, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_pwm1", 114, pwm1, 0);
    check("async_pwm2", 114, pwm2, 0);
    check("async_dir1", 114, dir1, 0);
    check("async_dir2", 114, dir2, 0);
    check("async_wdog", 114, wdog_trip, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // No drive until a new frame; then smallest non-zero magnitude
    expect_period(0, 0, 0, 1'b0, 1'b0);
    expect_period(1, 0, 0, 1'b0, 1'b0);
    drain();
    send_frame(8'h01, 8'h00, 2 * PER + 110);
    expect_period(3, 4, 0, 1'b0, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
